// File: rtl/alu_seq_if.sv
// Request/result channel between the instruction decoder, alu_seq and the register file.
// valid/ready: a transfer occurs on a rising clk edge where both valid and ready are high; the sender keeps its payload stable while valid is high and ready is low.
interface alu_seq_if #(parameter int SIZE = 16);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_op;
  logic            in_bw;
  logic [SIZE-1:0] in_src;
  logic [SIZE-1:0] in_dst;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out_result;
  logic            out_we;
  logic            out_illegal;

  modport master (
    output in_valid, in_op, in_bw, in_src, in_dst, out_ready,
    input  in_ready, out_valid, out_result, out_we, out_illegal
  );

  modport slave (
    input  in_valid, in_op, in_bw, in_src, in_dst, out_ready,
    output in_ready, out_valid, out_result, out_we, out_illegal
  );
endinterface

// File: rtl/alu_seq.sv
// Three-state sequencer around the combinational ALU: decodes MSP430 format-I opcodes,
// owns the C/V/N/Z flags and hands the write-back result out over valid/ready.
module alu_seq #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  alu_seq_if.slave        bus,
  output logic [SIZE-1:0] alu_src,
  output logic [SIZE-1:0] alu_dst,
  output logic            alu_bw,
  output logic            alu_cin,
  output logic [5:0]      alu_fs,
  input  logic [SIZE-1:0] alu_out,
  input  logic [3:0]      alu_cvnz,
  input  logic            sr_we,
  input  logic [3:0]      sr_wdata,
  output logic [3:0]      sr_flags,
  output logic [1:0]      dbg_state
);
  localparam int HALF = SIZE / 2;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [5:0]      dec_fs;
  logic            dec_cin;
  logic            dec_ill;
  logic [SIZE-1:0] res_w;
  logic            src_msb;
  logic            dst_msb;

  assign dbg_state = state;

  // Opcode decode; carry-in uses the flag value before any same-edge sr_we write.
  always_comb begin
    dec_fs  = 6'b000000;
    dec_cin = 1'b0;
    dec_ill = 1'b0;
    case (bus.in_op)
      4'h4: dec_fs = 6'b000010;
      4'h5: dec_fs = 6'b000000;
      4'h6: begin dec_fs = 6'b000000; dec_cin = sr_flags[3]; end
      4'h7: begin dec_fs = 6'b000001; dec_cin = sr_flags[3]; end
      4'h8, 4'h9: begin dec_fs = 6'b000001; dec_cin = 1'b1; end
      4'hB, 4'hF: dec_fs = 6'b010000;
      4'hC: dec_fs = 6'b010001;
      4'hD: dec_fs = 6'b010010;
      4'hE: dec_fs = 6'b010011;
      default: dec_ill = 1'b1;
    endcase
  end

  always_comb begin
    res_w = alu_out;
    if (alu_bw) res_w[SIZE-1:HALF] = '0;
    src_msb = alu_bw ? alu_src[HALF-1] : alu_src[SIZE-1];
    dst_msb = alu_bw ? alu_dst[HALF-1] : alu_dst[SIZE-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      op_q            <= 4'h0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.out_we      <= 1'b0;
      bus.out_illegal <= 1'b0;
      bus.out_result  <= '0;
      sr_flags        <= 4'b0000;
      alu_src         <= '0;
      alu_dst         <= '0;
      alu_bw          <= 1'b0;
      alu_cin         <= 1'b0;
      alu_fs          <= 6'b000000;
    end else begin
      // A flag update at the end of EXEC is assigned later and overrides this write.
      if (sr_we) sr_flags <= sr_wdata;
      case (state)
        IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            bus.in_ready <= 1'b0;
            if (dec_ill) begin
              bus.out_valid   <= 1'b1;
              bus.out_illegal <= 1'b1;
              bus.out_we      <= 1'b0;
              bus.out_result  <= '0;
              state           <= DONE;
            end else begin
              op_q    <= bus.in_op;
              alu_src <= bus.in_src;
              alu_dst <= bus.in_dst;
              alu_bw  <= bus.in_bw;
              alu_fs  <= dec_fs;
              alu_cin <= dec_cin;
              state   <= EXEC;
            end
          end
        end
        EXEC: begin
          bus.out_result  <= res_w;
          bus.out_illegal <= 1'b0;
          bus.out_we      <= !(op_q == 4'h9 || op_q == 4'hB);
          bus.out_valid   <= 1'b1;
          state           <= DONE;
          case (op_q)
            4'h5, 4'h6, 4'h7, 4'h8, 4'h9: sr_flags <= alu_cvnz;
            4'hB, 4'hF: sr_flags <= {~alu_cvnz[0], 1'b0, alu_cvnz[1:0]};
            4'hE: sr_flags <= {~alu_cvnz[0], src_msb & dst_msb, alu_cvnz[1:0]};
            default: ;
          endcase
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Multi-cycle sequencer that issues operations to the combinational 16-bit ALU and consumes its results. It translates MSP430 format-I opcodes into ALU function-select, byte/word and carry-in controls. It owns the status flags C, Z, N, V and returns the write-back result to the register file over a valid/ready handshake. It sits between the instruction decoder and the register file / SR.

Parameters:
SIZE, 16, datapath width; byte mode uses bits [SIZE/2-1:0].

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operation request valid.
in_ready  output  1  sequencer can accept an operation.
in_op  input  4  MSP430 format-I opcode (4=MOV … F=AND).
in_bw  input  1  1 = byte operation.
in_src  input  SIZE  source operand.
in_dst  input  SIZE  destination operand.
alu_src  output  SIZE  to ALU SRC.
alu_dst  output  SIZE  to ALU DST.
alu_bw  output  1  to ALU BW.
alu_cin  output  1  to ALU Cin.
alu_fs  output  6  to ALU FS.
alu_out  input  SIZE  from ALU_OUT.
alu_cvnz  input  4  from ALU CVNZ_alu ({C,V,N,Z}).
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_result  output  SIZE  write-back value.
out_we  output  1  destination must be written.
out_illegal  output  1  opcode not supported.
sr_we  input  1  direct flag write (MOV to SR).
sr_wdata  input  4  {C,V,N,Z} for direct write.
sr_flags  output  4  current {C,V,N,Z}.

Behaviour:
- Single clock (clk); synchronous active-high reset (rst).
- Reset values:
  - state = IDLE; in_ready = 1.
  - out_valid, out_we, out_illegal = 0; out_result = 0; sr_flags = 0.
  - alu_* outputs = 0.
- FS encoding, fixed:
  - FS[5] = 0 always.
  - FS[4] = 0 selects arithmetic; FS[1:0]: 00 = SRC+DST+Cin, 01 = ~SRC+DST+Cin, 10 = pass SRC.
  - FS[4] = 1 selects logic; FS[3:0]: 0000 = AND, 0001 = ~SRC&DST, 0010 = OR, 0011 = XOR.
- Opcode map (fs / cin / writes dst / flag rule):
  - MOV: pass SRC / 0 / yes / flags unchanged.
  - ADD: 00 / 0 / yes / ALU CVNZ.
  - ADDC: 00 / C / yes / ALU CVNZ.
  - SUBC: 01 / C / yes / ALU CVNZ.
  - SUB: 01 / 1 / yes / ALU CVNZ.
  - CMP: 01 / 1 / no / ALU CVNZ.
  - BIT: AND / 0 / no / C = ~Z, V = 0.
  - BIC: ~SRC&DST / 0 / yes / flags unchanged.
  - BIS: OR / 0 / yes / flags unchanged.
  - XOR: XOR / 0 / yes / C = ~Z, V = SRC_msb & DST_msb.
  - AND: AND / 0 / yes / C = ~Z, V = 0.
  - For logic ops N and Z come from the ALU. "msb" is bit 7 in byte mode, bit SIZE-1 otherwise.
- Illegal opcodes 0–3 and A (DADD unsupported):
  - Accepted normally and skip EXEC: IDLE -> DONE directly.
  - out_illegal = 1, out_result = 0, out_we = 0, flags unchanged.
- FSM, three states:
  - IDLE: in_ready = 1. On in_valid & in_ready, latch op, bw, src, dst and Cin. Cin is taken from the pre-edge C, so a same-cycle sr_we does not affect it. Go to EXEC.
  - EXEC: one cycle. alu_* are driven from the latched registers. At the end of the cycle capture alu_out and apply the flag rule, then go to DONE.
  - DONE: out_valid = 1 and out_* are held stable until out_ready. On out_valid & out_ready go to IDLE; out_valid drops the next cycle.
- Latency and throughput:
  - Accept in cycle n; out_valid in cycle n+2.
  - Minimum one IDLE cycle between operations, so peak throughput is one operation per 3 cycles.
  - in_ready = 0 in EXEC and DONE.
- Byte mode: out_result[SIZE-1:SIZE/2] is forced to 0; the ALU provides C, N, Z from the byte.
- alu_* outside EXEC: hold the last driven values. They are not observed by checkers.
- sr_we:
  - Writes the flags in any state.
  - If it coincides with an EXEC-end flag update that modifies flags, the ALU update wins and sr_we is dropped.
  - If the op leaves flags unchanged (MOV/BIC/BIS), sr_we takes effect.
- Reset mid-operation: any in-flight operation is discarded; outputs return to reset values on the next edge.

Test Plan:
- Word ADD: src=0xFFFF, dst=0x0001 -> accepted cycle n, out_valid at n+2; out_result=0x0000, out_we=1, sr_flags={C=1,V=0,N=0,Z=1}.
- Byte SUB: in_bw=1, src=0x0001, dst=0x1280 -> out_result=0x007F, sr_flags={C=1,V=1,N=0,Z=0}.
- ADDC chain: previous C=1, then ADDC src=0x0000, dst=0x7FFF -> out_result=0x8000, V=1, N=1, C=0, Z=0.
- CMP and BIT: CMP src=dst=0x1234 -> out_we=0, Z=1, C=1. BIT src=0x00F0, dst=0x000F -> out_we=0, Z=1, C=0, V=0.
- Backpressure and illegal opcode:
  - out_ready held low 5 cycles -> out_valid and out_result stable, in_ready=0 throughout.
  - in_op=0xA -> out_illegal=1, out_result=0, flags unchanged, out_valid one cycle after accept.
- sr_we collision and reset:
  - sr_we=4'b1111 at the EXEC end of ADD 1+1 -> sr_flags=0000 (the ALU update wins).
  - Same collision during BIS -> sr_flags=1111.
  - rst asserted in EXEC -> out_valid=0, in_ready=1, sr_flags=0 next cycle.
